// File: rtl/final_layer_sched.sv
// Final-layer scheduler: streams weight chunks for every output class and
// matches them against the latched activations with XNOR-popcount. It keeps
// the best class, with ties going to the lower class index.
module final_layer_sched #(
  parameter int NUM_INPUTS  = 196,
  parameter int NUM_CLASSES = 10,
  parameter int CHUNK       = 14,
  localparam int NUM_CHUNKS = NUM_INPUTS / CHUNK,
  localparam int N_RD       = NUM_CLASSES * NUM_CHUNKS,
  localparam int AW         = (N_RD > 1) ? $clog2(N_RD) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_INPUTS-1:0] data_in,
  output logic                  w_rd_en,
  output logic [AW-1:0]         w_addr,
  input  logic                  w_gnt,
  input  logic [CHUNK-1:0]      w_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            answer,
  output logic [7:0]            score
);

  localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if (NUM_INPUTS % CHUNK != 0) begin : g_chunk_check
    $error("NUM_INPUTS must be a multiple of CHUNK");
  end
  if (NUM_CLASSES < 2 || NUM_CLASSES > 16) begin : g_class_check
    $error("NUM_CLASSES must be in 2..16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [NUM_INPUTS-1:0]   data_reg;
  logic [CW-1:0]           chunk;
  logic [3:0]              cls;
  logic                    rd_valid;
  logic [CW-1:0]           rd_chunk;
  logic [3:0]              rd_class;
  logic                    rd_last;
  logic [7:0]              acc;
  logic [7:0]              best_score;
  logic [3:0]              best_class;
  logic                    issue;
  logic                    last_addr;
  logic [CHUNK-1:0]        match_bits;
  logic [7:0]              ret_sum;
  logic                    take;
  logic [7:0]              best_nxt;
  logic [3:0]              best_class_nxt;

  function automatic logic [7:0] popcount(input logic [CHUNK-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int unsigned i = 0; i < CHUNK; i++) c = c + 8'(v[i]);
    return c;
  endfunction

  assign issue     = (state == RUN) && w_gnt;
  assign last_addr = (w_addr == AW'(N_RD - 1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and Moore outputs
  always_comb begin
    state_nxt = state;
    w_rd_en   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN: begin
        w_rd_en = 1'b1;
        busy    = 1'b1;
        if (w_gnt && last_addr) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Score the returning chunk and decide whether it completes a new best class
  always_comb begin
    match_bits     = ~(w_rdata ^ data_reg[int'(rd_chunk) * CHUNK +: CHUNK]);
    ret_sum        = acc + popcount(match_bits);
    take           = rd_valid && rd_last && ((rd_class == '0) || (ret_sum > best_score));
    best_nxt       = take ? ret_sum  : best_score;
    best_class_nxt = take ? rd_class : best_class;
  end

  // Address/counter sequencing, return pipeline, accumulation and result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      data_reg   <= '0;
      w_addr     <= '0;
      chunk      <= '0;
      cls        <= '0;
      rd_valid   <= 1'b0;
      rd_chunk   <= '0;
      rd_class   <= '0;
      rd_last    <= 1'b0;
      acc        <= '0;
      best_score <= '0;
      best_class <= '0;
      answer     <= '0;
      score      <= '0;
    end else begin
      rd_valid <= issue;
      if (state == IDLE && start) begin
        data_reg   <= data_in;
        w_addr     <= '0;
        chunk      <= '0;
        cls        <= '0;
        acc        <= '0;
        best_score <= '0;
        best_class <= '0;
      end
      if (issue) begin
        rd_chunk <= chunk;
        rd_class <= cls;
        rd_last  <= (chunk == CW'(NUM_CHUNKS - 1));
        w_addr   <= last_addr ? '0 : w_addr + 1'b1;
        if (chunk == CW'(NUM_CHUNKS - 1)) begin
          chunk <= '0;
          cls   <= cls + 1'b1;
        end else begin
          chunk <= chunk + 1'b1;
        end
      end
      if (rd_valid) begin
        acc        <= rd_last ? '0 : ret_sum;
        best_score <= best_nxt;
        best_class <= best_class_nxt;
      end
      // The final return lands in DRAIN, so the result is taken from the
      // combinational best to make it visible during the DONE cycle.
      if (state == DRAIN) begin
        answer <= best_class_nxt;
        score  <= best_nxt;
      end
    end
  end

endmodule

// File: tb/tb_final_layer_sched.sv
// Self-checking bench for final_layer_sched: weight-memory responder,
// whole-vector scoring model, per-cycle output compare and directed cases.
module tb_final_layer_sched;

  localparam int NI = 196;
  localparam int NC = 10;
  localparam int CH = 14;
  localparam int NK = NI / CH;
  localparam int NR = NC * NK;
  localparam int AW = $clog2(NR);

  logic          clk = 1'b0;
  logic          reset, start, w_gnt;
  logic [NI-1:0] data_in;
  logic          w_rd_en, busy, done;
  logic [AW-1:0] w_addr;
  logic [CH-1:0] w_rdata;
  logic [3:0]    answer;
  logic [7:0]    score;

  final_layer_sched #(.NUM_INPUTS(NI), .NUM_CLASSES(NC), .CHUNK(CH)) dut (
    .clock(clk), .reset(reset), .start(start), .data_in(data_in),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_gnt(w_gnt), .w_rdata(w_rdata),
    .busy(busy), .done(done), .answer(answer), .score(score)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Weight memory: answers an issued request in the following cycle, garbage otherwise
  logic [CH-1:0] mem [NR];
  always begin
    logic          iss;
    logic [AW-1:0] ia;
    @(posedge clk);
    iss = (w_rd_en === 1'b1) && (w_gnt === 1'b1);
    ia  = w_addr;
    #1;
    w_rdata = iss ? mem[ia] : CH'($urandom);
  end

  // Whole-vector model: each class score is the XNOR popcount over all inputs
  int g_ans, g_sc;
  task automatic golden(input logic [NI-1:0] d);
    logic [NI-1:0] w;
    int s;
    g_ans = 0;
    g_sc  = 0;
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < NK; k++) w[k*CH +: CH] = mem[c*NK + k];
      s = $countones(~(d ^ w));
      if (c == 0 || s > g_sc) begin
        g_ans = c;
        g_sc  = s;
      end
    end
  endtask

  // Model progress: reads issued so far, cycles after the last read
  bit m_active = 1'b0;
  int m_issued = 0;
  int m_tail   = 0;
  int exp_ans  = 0;
  int exp_sc   = 0;
  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0; m_issued = 0; m_tail = 0; exp_ans = 0; exp_sc = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_issued = 0; m_tail = 0;
        golden(data_in);
      end
    end else if (m_issued < NR) begin
      if (w_gnt) m_issued++;
    end else begin
      m_tail++;
      if (m_tail == 1) begin exp_ans = g_ans; exp_sc = g_sc; end
      if (m_tail == 2) m_active = 1'b0;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    bit e_rd, e_done;
    if (chk_en) begin
      e_rd   = m_active && (m_issued < NR);
      e_done = m_active && (m_issued == NR) && (m_tail == 1);
      chk("w_rd_en", 32'(w_rd_en), 32'(e_rd));
      chk("w_addr",  32'(w_addr),  e_rd ? 32'(m_issued) : 32'd0);
      chk("busy",    32'(busy),    32'(m_active && !e_done));
      chk("done",    32'(done),    32'(e_done));
      chk("answer",  32'(answer),  32'(exp_ans));
      chk("score",   32'(score),   32'(exp_sc));
    end
  end

  function automatic logic [NI-1:0] ones_n(input int n);
    logic [NI-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic load_class(input int c, input logic [NI-1:0] v);
    for (int k = 0; k < NK; k++) mem[c*NK + k] = v[k*CH +: CH];
  endtask

  function automatic logic [NI-1:0] rand_vec();
    logic [NI-1:0] v;
    for (int i = 0; i < NI; i++) v[i] = 1'($urandom);
    return v;
  endfunction

  // One run of 170 cycles; rel counts cycles after the accepting edge (1 = first RUN cycle)
  task automatic run_case(input int gl_at, input int gl_len, input int rst_at,
                          input int rs1, input int rs2,
                          output int ndone, output int drel, output int gaddr);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0; drel = -1; gaddr = -1;
    for (int rel = 1; rel <= 170; rel++) begin
      if (rel > 1) @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (drel < 0) drel = rel;
      end
      if (gl_len > 0 && rel == gl_at + gl_len - 1) gaddr = int'(w_addr);
      w_gnt = !(rel >= gl_at && rel < gl_at + gl_len);
      reset = (rel == rst_at);
      start = (rel == rs1) || (rel == rs2);
    end
    start = 1'b0; reset = 1'b0; w_gnt = 1'b1;
  endtask

  task automatic setup_class7();
    data_in = '1;
    for (int c = 0; c < NC; c++) load_class(c, (c == 7) ? '1 : '0);
  endtask

  int nd, dr, ga;

  initial begin
    reset = 1'b1; start = 1'b0; w_gnt = 1'b1; data_in = '0; w_rdata = '0;
    for (int i = 0; i < NR; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    start = 1'b1;                      // start during reset must be overridden
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("rst_rd_en", 32'(w_rd_en), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_addr",  32'(w_addr), 0);
    chk("rst_ans",   32'(answer), 0);
    chk("rst_score", 32'(score), 0);
    chk_en = 1'b1;

    // Only class 7 matches the activations
    setup_class7();
    run_case(0, 0, 0, 0, 0, nd, dr, ga);
    chk("t1_model_ans", 32'(g_ans), 7);
    chk("t1_model_sc",  32'(g_sc), 196);
    chk("t1_ndone", 32'(nd), 1);
    chk("t1_done_at", 32'(dr), 142);
    chk("t1_ans", 32'(answer), 7);
    chk("t1_score", 32'(score), 196);

    // Tie between classes 3 and 8 resolves to the lower index
    data_in = '1;
    for (int c = 0; c < NC; c++) load_class(c, ones_n((c == 3 || c == 8) ? 150 : 100));
    run_case(0, 0, 0, 0, 0, nd, dr, ga);
    chk("t2_model_ans", 32'(g_ans), 3);
    chk("t2_ans", 32'(answer), 3);
    chk("t2_score", 32'(score), 150);

    // Every class equals the activations
    data_in = rand_vec();
    for (int c = 0; c < NC; c++) load_class(c, data_in);
    run_case(0, 0, 0, 0, 0, nd, dr, ga);
    chk("t3_ans", 32'(answer), 0);
    chk("t3_score", 32'(score), 196);

    // Grant withheld for five cycles from T+40
    setup_class7();
    run_case(40, 5, 0, 0, 0, nd, dr, ga);
    chk("t4_addr_held", 32'(ga), 39);
    chk("t4_done_at", 32'(dr), 147);
    chk("t4_ndone", 32'(nd), 1);
    chk("t4_ans", 32'(answer), 7);
    chk("t4_score", 32'(score), 196);

    // Reset mid-run aborts, then a fresh run completes normally
    run_case(0, 0, 50, 0, 0, nd, dr, ga);
    chk("t5_ndone", 32'(nd), 0);
    chk("t5_ans", 32'(answer), 0);
    chk("t5_score", 32'(score), 0);
    run_case(0, 0, 0, 0, 0, nd, dr, ga);
    chk("t5b_done_at", 32'(dr), 142);
    chk("t5b_ans", 32'(answer), 7);

    // Start re-pulsed while busy and in the DONE cycle
    data_in = '1;
    for (int c = 0; c < NC; c++) load_class(c, ones_n((c == 3 || c == 8) ? 150 : 100));
    run_case(0, 0, 0, 20, 142, nd, dr, ga);
    chk("t6_ndone", 32'(nd), 1);
    chk("t6_done_at", 32'(dr), 142);
    chk("t6_ans", 32'(answer), 3);

    // Random activations and weights with a short grant gap
    data_in = rand_vec();
    for (int c = 0; c < NC; c++) load_class(c, rand_vec());
    run_case(10, 3, 0, 0, 0, nd, dr, ga);
    chk("t7_done_at", 32'(dr), 145);
    chk("t7_ans", 32'(answer), 32'(g_ans));
    chk("t7_score", 32'(score), 32'(g_sc));

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
